uart_rx_fifo: RTL and testbench

//  Second-generation UART receiver for the ALU system's host link. It oversamples rx_in,

---
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5..MAX_DATA_W data bits, optional parity, 1/2 stop bits)
// that pushes each frame with its error flags into a small first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int PRESCALE_W = 6,
    parameter int MAX_DATA_W = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic                  rd_en,
    input  logic                  clr_ovr,
    output logic [MAX_DATA_W-1:0] rd_data,
    output logic                  rd_par_err,
    output logic                  rd_stp_err,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  overrun
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low level
    // START  | start bit; a voted 1 is treated as a glitch
    // DATA   | data bits, LSB first
    // PARITY | parity bit
    // STOP1  | first stop bit
    // STOP2  | second stop bit
    // PUSH   | write the frame into the FIFO
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH
    } state_t;

    state_t state, state_nxt;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [3:0]            bit_cnt;
    logic [3:0]            last_bit;
    logic                  smp0, smp1, voted, vote_vld;
    logic [MAX_DATA_W-1:0] data_sr;
    logic                  par_err, stp_err;
    logic                  busy, bit_end;

    assign half     = prescale >> 1;
    assign busy     = (state != S_IDLE) && (state != S_PUSH);
    assign bit_end  = busy && (edge_cnt >= prescale - PRESCALE_W'(1));
    assign last_bit = (data_bits > 4'(MAX_DATA_W)) ? 4'(MAX_DATA_W - 1) : data_bits - 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt <= '0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            voted    <= 1'b0;
            vote_vld <= 1'b0;
            bit_cnt  <= '0;
            data_sr  <= '0;
            par_err  <= 1'b0;
            stp_err  <= 1'b0;
        end else begin
            vote_vld <= 1'b0;
            if (!busy || bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + PRESCALE_W'(1);

            // Three samples around mid-bit; the vote is usable one cycle later.
            if (busy) begin
                if (edge_cnt == half - PRESCALE_W'(1)) smp0 <= rx_in;
                if (edge_cnt == half) smp1 <= rx_in;
                if (edge_cnt == half + PRESCALE_W'(1)) begin
                    voted    <= (smp0 & smp1) | (smp0 & rx_in) | (smp1 & rx_in);
                    vote_vld <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    data_sr <= '0;
                    par_err <= 1'b0;
                    stp_err <= 1'b0;
                end
                S_DATA: begin
                    if (vote_vld && (bit_cnt < 4'(MAX_DATA_W))) data_sr[bit_cnt] <= voted;
                    if (bit_end) bit_cnt <= bit_cnt + 4'd1;
                end
                S_PARITY: begin
                    if (vote_vld) par_err <= voted ^ par_typ ^ (^data_sr);
                end
                S_STOP1, S_STOP2: begin
                    if (vote_vld && !voted) stp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_in) state_nxt = S_START;
            S_START: begin
                if (vote_vld && voted) state_nxt = S_IDLE;
                else if (bit_end)      state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_cnt >= last_bit))
                    state_nxt = par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (bit_end) state_nxt = S_STOP1;
            S_STOP1: begin
                if (!stop2 && vote_vld)   state_nxt = S_PUSH;
                else if (stop2 && bit_end) state_nxt = S_STOP2;
            end
            S_STOP2:  if (vote_vld) state_nxt = S_PUSH;
            S_PUSH:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    logic [MAX_DATA_W+1:0] mem [FIFO_DEPTH];
    logic [MAX_DATA_W+1:0] head;
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      count;
    logic                  push_req, pop, full, wr_ok, ovr_evt;

    assign push_req = (state == S_PUSH);
    assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign pop      = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the frame.
    assign wr_ok    = push_req && (!full || pop);
    assign ovr_evt  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= {stp_err, par_err, data_sr};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            if (ovr_evt)      overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = full;
    assign fifo_count = count;
    assign rd_data    = fifo_empty ? '0 : head[MAX_DATA_W-1:0];
    assign rd_par_err = fifo_empty ? 1'b0 : head[MAX_DATA_W];
    assign rd_stp_err = fifo_empty ? 1'b0 : head[MAX_DATA_W+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random frames, checked against a queue model
// that derives each entry from the bits placed on the line.
module tb_uart_rx_fifo;
    localparam int PW = 6, DW = 9, DEPTH = 4, AW = 2;

    logic          clk = 1'b0;
    logic          rst, rx_in, par_en, par_typ, stop2, rd_en, clr_ovr;
    logic [PW-1:0] prescale;
    logic [3:0]    data_bits;
    logic [DW-1:0] rd_data;
    logic          rd_par_err, rd_stp_err, fifo_empty, fifo_full, overrun;
    logic [AW:0]   fifo_count;

    always #5 clk = ~clk;

    uart_rx_fifo #(.PRESCALE_W(PW), .MAX_DATA_W(DW), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .data_bits(data_bits),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .rd_en(rd_en), .clr_ovr(clr_ovr),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_stp_err(rd_stp_err),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .overrun(overrun)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        logic          s;
    } ent_t;

    ent_t q[$];
    bit   ovr_m;
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "/count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "/empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        check({tag, "/full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
        check({tag, "/overrun"}, 32'(overrun), 32'(ovr_m));
        if (q.size() > 0) begin
            check({tag, "/data"}, 32'(rd_data), 32'(q[0].d));
            check({tag, "/par_err"}, 32'(rd_par_err), 32'(q[0].p));
            check({tag, "/stp_err"}, 32'(rd_stp_err), 32'(q[0].s));
        end
    endtask

    task automatic set_cfg(input int p, input int nd, input bit pe, input bit pt, input bit s2);
        prescale  = PW'(p);
        data_bits = 4'(nd);
        par_en    = pe;
        par_typ   = pt;
        stop2     = s2;
    endtask

    // Drives one whole frame; stop_lo[i] pulls stop bit i low. The frame is written one
    // cycle after the last stop-bit vote, which lands at (nbits-1)*P + P/2 + 4 cycles after
    // the start edge; pop_at_push raises rd_en in exactly that cycle.
    task automatic send_frame(input logic [DW-1:0] val, input bit bad_par,
                              input bit [1:0] stop_lo, input bit pop_at_push);
        int   p = int'(prescale);
        int   nd = int'(data_bits);
        int   mask = (1 << nd) - 1;
        int   dv = int'(val) & mask;
        bit   bits[$];
        bit   exp_par;
        bit   par_sent;
        bit   stp;
        int   nbits, push_cyc;
        ent_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(dv[i]);
        exp_par  = ($countones(dv) % 2 == 1) ^ par_typ;
        par_sent = exp_par ^ bad_par;
        if (par_en) bits.push_back(par_sent);
        bits.push_back(~stop_lo[0]);
        stp = stop_lo[0];
        if (stop2) begin
            bits.push_back(~stop_lo[1]);
            stp = stp | stop_lo[1];
        end
        nbits    = bits.size();
        push_cyc = (nbits - 1) * p + p / 2 + 4;
        for (int c = 0; c < (nbits + 2) * p; c++) begin
            rx_in = (c < nbits * p) ? bits[c / p] : 1'b1;
            rd_en = pop_at_push && (c == push_cyc);
            tick();
        end
        rd_en = 1'b0;
        e.d = DW'(dv);
        e.p = par_en && (par_sent != exp_par);
        e.s = stp;
        if (q.size() == DEPTH && !pop_at_push) begin
            ovr_m = 1'b1;
        end else begin
            if (pop_at_push && q.size() > 0) void'(q.pop_front());
            q.push_back(e);
        end
    endtask

    task automatic pop_check(input string tag);
        check_status(tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clear_overrun();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        ovr_m   = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, nd;
        bit pe, pt, s2;

        rst = 1'b0; rx_in = 1'b1; rd_en = 1'b0; clr_ovr = 1'b0;
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        ovr_m = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        check("reset/rd_data", 32'(rd_data), 32'h0);
        check("reset/rd_par_err", 32'(rd_par_err), 32'h0);
        check("reset/rd_stp_err", 32'(rd_stp_err), 32'h0);
        check_status("reset");

        // 8N1 at prescale 8
        send_frame(9'h0A5, 1'b0, 2'b00, 1'b0);
        check_status("t1");
        check("t1/data_abs", 32'(rd_data), 32'h0A5);
        pop_check("t1_pop");
        check_status("t1_after");

        // 7 bits, odd parity, two stops, corrupted parity bit
        set_cfg(8, 7, 1'b1, 1'b1, 1'b1);
        send_frame(9'h035, 1'b1, 2'b00, 1'b0);
        check("t2/par_abs", 32'(rd_par_err), 32'h1);
        check("t2/data_abs", 32'(rd_data), 32'h035);
        pop_check("t2_pop");

        // second stop bit low
        set_cfg(8, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h05A, 1'b0, 2'b10, 1'b0);
        check("t3/stp_abs", 32'(rd_stp_err), 32'h1);
        pop_check("t3_pop");

        // 2-cycle start glitch pushes nothing; the next frame decodes normally
        rx_in = 1'b0;
        tick(); tick();
        rx_in = 1'b1;
        for (int i = 0; i < 3 * 8; i++) tick();
        check_status("t3_glitch");
        send_frame(9'h012, 1'b0, 2'b00, 1'b0);
        pop_check("t3_recover");

        // overflow: five frames, no reads
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) send_frame(DW'(i), 1'b0, 2'b00, 1'b0);
        check("t4/full_abs", 32'(fifo_full), 32'h1);
        check("t4/ovr_abs", 32'(overrun), 32'h1);
        for (int i = 0; i < 4; i++) pop_check("t4_pop");
        check_status("t4_empty");
        clear_overrun();
        check_status("t4_clr");

        // full FIFO with a pop in the push cycle
        for (int i = 0; i < 4; i++) send_frame(DW'(9'h11 + i), 1'b0, 2'b00, 1'b0);
        check_status("t5_full");
        send_frame(9'h015, 1'b0, 2'b00, 1'b1);
        check("t5/count_abs", 32'(fifo_count), 32'd4);
        check("t5/ovr_abs", 32'(overrun), 32'h0);
        for (int i = 0; i < 4; i++) pop_check("t5_pop");
        check_status("t5_empty");

        // reset in the middle of a frame discards it and the stored entry
        send_frame(9'h044, 1'b0, 2'b00, 1'b0);
        rx_in = 1'b0;
        for (int i = 0; i < 8 * 3; i++) begin
            rx_in = (i < 8) ? 1'b0 : i[3];
            tick();
        end
        rx_in = 1'b1;
        rst   = 1'b0;
        tick(); tick();
        rst = 1'b1;
        q.delete();
        ovr_m = 1'b0;
        check_status("t6_reset");
        send_frame(9'h03C, 1'b0, 2'b00, 1'b0);
        check("t6/data_abs", 32'(rd_data), 32'h03C);
        check_status("t6");
        pop_check("t6_pop");

        // random frames, configurations and read patterns
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            nd = int'($urandom_range(5, 9));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            set_cfg(p, nd, pe, pt, s2);
            send_frame(DW'($urandom), pe && ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       ($urandom_range(0, 2) == 0));
            check_status("rnd");
            if ($urandom_range(0, 1) == 1) pop_check("rnd_pop");
            if (ovr_m && $urandom_range(0, 1) == 1) begin
                clear_overrun();
                check_status("rnd_clr");
            end
        end
        while (q.size() > 0) pop_check("drain");
        check_status("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
